// File: rtl/core_cache_pkg.sv
// ----------------------------------------------------------------------------
// core_cache_pkg
// Shared types and default widths for the cache/memory arbitration slice.
//   arb_state_t : arbiter FSM states (IDLE, CMD, RDWAIT)
//   ARB_AW      : default memory word-address width
//   ARB_DW      : default line data width
//   ARB_BW      : default byte-enable width
// ----------------------------------------------------------------------------
package core_cache_pkg;

    localparam int ARB_AW = 26;
    localparam int ARB_DW = 128;
    localparam int ARB_BW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/core_rr_arb2.sv
// ----------------------------------------------------------------------------
// core_rr_arb2
// Two-way round-robin grant selection, purely combinational.
//   req[1:0] in  : request per port
//   last     in  : port that completed the most recent transaction
//   grant    out : selected port (valid when any_req is 1)
//   any_req  out : at least one port is requesting
// A lone requester always wins; on a tie the port that was not served last
// wins, so two busy masters alternate.
// ----------------------------------------------------------------------------
module core_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       any_req
);

    assign any_req = req[0] | req[1];

    // Tie-break on the opposite of the last served port.
    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/core_cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// core_cache_mem_arbiter
// Shares one line-granular memory port between two cache masters
// (port 0 = icache, port 1 = dcache). Round-robin arbitration, a single
// transaction in flight, read data steered to the issuing master.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_sN_addr/byte_en/writedata    master N command (N = 0, 1)
//   i_sN_read/i_sN_write           master N strobes, held until !o_sN_waitrequest
//   o_sN_readdata                  memory read line, broadcast to both masters
//   o_sN_readdata_valid            read line valid, only to the owning master
//   o_sN_waitrequest               stall to master N
//   o_m_addr/byte_en/writedata     muxed command to memory
//   o_m_read/o_m_write             memory strobes
//   i_m_readdata/_valid            memory read line and its strobe
//   i_m_waitrequest                memory command stall
//   o_busy                         FSM not idle
//   o_err                          sticky: read data arrived outside RDWAIT
//   cnt_stall0/1                   cycles master N requested while stalled
// ----------------------------------------------------------------------------
module core_cache_mem_arbiter
    import core_cache_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW,
    parameter int BW = ARB_BW
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic [AW-1:0] i_s0_addr,
    input  logic [BW-1:0] i_s0_byte_en,
    input  logic [DW-1:0] i_s0_writedata,
    input  logic          i_s0_read,
    input  logic          i_s0_write,
    output logic [DW-1:0] o_s0_readdata,
    output logic          o_s0_readdata_valid,
    output logic          o_s0_waitrequest,

    input  logic [AW-1:0] i_s1_addr,
    input  logic [BW-1:0] i_s1_byte_en,
    input  logic [DW-1:0] i_s1_writedata,
    input  logic          i_s1_read,
    input  logic          i_s1_write,
    output logic [DW-1:0] o_s1_readdata,
    output logic          o_s1_readdata_valid,
    output logic          o_s1_waitrequest,

    output logic [AW-1:0] o_m_addr,
    output logic [BW-1:0] o_m_byte_en,
    output logic [DW-1:0] o_m_writedata,
    output logic          o_m_read,
    output logic          o_m_write,
    input  logic [DW-1:0] i_m_readdata,
    input  logic          i_m_readdata_valid,
    input  logic          i_m_waitrequest,

    output logic          o_busy,
    output logic          o_err,
    output logic [31:0]   cnt_stall0,
    output logic [31:0]   cnt_stall1
);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          grant;
    logic          grant_nxt;
    logic          last;
    logic          last_nxt;
    logic          err_set;

    logic [1:0]    req;
    logic          arb_grant;
    logic          arb_any;

    logic          g_read;
    logic          g_write;
    logic [AW-1:0] g_addr;
    logic [BW-1:0] g_byte_en;
    logic [DW-1:0] g_writedata;

    assign req[0] = i_s0_read | i_s0_write;
    assign req[1] = i_s1_read | i_s1_write;

    core_rr_arb2 u_rr_arb (
        .req     (req),
        .last    (last),
        .grant   (arb_grant),
        .any_req (arb_any)
    );

    // Read data is broadcast; only the valid strobe is steered.
    assign o_s0_readdata = i_m_readdata;
    assign o_s1_readdata = i_m_readdata;
    assign o_busy        = (state != IDLE);

    // Command of the currently granted master.
    always_comb begin
        g_read      = grant ? i_s1_read      : i_s0_read;
        g_write     = grant ? i_s1_write     : i_s0_write;
        g_addr      = grant ? i_s1_addr      : i_s0_addr;
        g_byte_en   = grant ? i_s1_byte_en   : i_s0_byte_en;
        g_writedata = grant ? i_s1_writedata : i_s0_writedata;
    end

    // Next-state and output decode. Masters are always stalled except the
    // granted one in CMD, which sees the memory stall directly. A read that
    // is presented together with a write takes precedence. Read data that
    // shows up while no read is outstanding is discarded and flagged.
    always_comb begin
        state_nxt           = state;
        grant_nxt           = grant;
        last_nxt            = last;
        err_set             = 1'b0;
        o_m_read            = 1'b0;
        o_m_write           = 1'b0;
        o_m_addr            = '0;
        o_m_byte_en         = '0;
        o_m_writedata       = '0;
        o_s0_waitrequest    = 1'b1;
        o_s1_waitrequest    = 1'b1;
        o_s0_readdata_valid = 1'b0;
        o_s1_readdata_valid = 1'b0;

        case (state)
            IDLE: begin
                err_set = i_m_readdata_valid;
                if (arb_any) begin
                    grant_nxt = arb_grant;
                    state_nxt = CMD;
                end
            end

            CMD: begin
                err_set       = i_m_readdata_valid;
                o_m_addr      = g_addr;
                o_m_byte_en   = g_byte_en;
                o_m_writedata = g_writedata;
                o_m_read      = g_read;
                o_m_write     = g_write & ~g_read;
                if (grant) begin
                    o_s1_waitrequest = i_m_waitrequest;
                end else begin
                    o_s0_waitrequest = i_m_waitrequest;
                end
                if (!g_read && !g_write) begin
                    // Master withdrew its request; nothing reached memory.
                    state_nxt = IDLE;
                end else if (!i_m_waitrequest) begin
                    if (g_read) begin
                        state_nxt = RDWAIT;
                    end else begin
                        last_nxt  = grant;
                        state_nxt = IDLE;
                    end
                end
            end

            RDWAIT: begin
                if (i_m_readdata_valid) begin
                    if (grant) begin
                        o_s1_readdata_valid = 1'b1;
                    end else begin
                        o_s0_readdata_valid = 1'b1;
                    end
                    last_nxt  = grant;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, grant and fairness history. last resets to 1 so port 0 wins
    // the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err <= 1'b0;
        end else if (err_set) begin
            o_err <= 1'b1;
        end
    end

    // Stall counters for the performance registers; they wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_stall0 <= '0;
            cnt_stall1 <= '0;
        end else begin
            if (req[0] && o_s0_waitrequest) begin
                cnt_stall0 <= cnt_stall0 + 32'd1;
            end
            if (req[1] && o_s1_waitrequest) begin
                cnt_stall1 <= cnt_stall1 + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_core_cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_core_cache_mem_arbiter
// Directed bench for core_cache_mem_arbiter with a behavioural memory model.
// Expected memory commands and read responses are queued when stimulus is
// issued; a monitor pops and compares whenever the DUT presents them.
// ----------------------------------------------------------------------------
module tb_core_cache_mem_arbiter;

    logic          clk = 1'b0;
    logic          rst_n;

    logic [25:0]   i_s0_addr;
    logic [3:0]    i_s0_byte_en;
    logic [127:0]  i_s0_writedata;
    logic          i_s0_read;
    logic          i_s0_write;
    logic [127:0]  o_s0_readdata;
    logic          o_s0_readdata_valid;
    logic          o_s0_waitrequest;

    logic [25:0]   i_s1_addr;
    logic [3:0]    i_s1_byte_en;
    logic [127:0]  i_s1_writedata;
    logic          i_s1_read;
    logic          i_s1_write;
    logic [127:0]  o_s1_readdata;
    logic          o_s1_readdata_valid;
    logic          o_s1_waitrequest;

    logic [25:0]   o_m_addr;
    logic [3:0]    o_m_byte_en;
    logic [127:0]  o_m_writedata;
    logic          o_m_read;
    logic          o_m_write;
    logic [127:0]  i_m_readdata;
    logic          i_m_readdata_valid;
    logic          i_m_waitrequest;

    logic          o_busy;
    logic          o_err;
    logic [31:0]   cnt_stall0;
    logic [31:0]   cnt_stall1;

    core_cache_mem_arbiter dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_s0_addr           (i_s0_addr),
        .i_s0_byte_en        (i_s0_byte_en),
        .i_s0_writedata      (i_s0_writedata),
        .i_s0_read           (i_s0_read),
        .i_s0_write          (i_s0_write),
        .o_s0_readdata       (o_s0_readdata),
        .o_s0_readdata_valid (o_s0_readdata_valid),
        .o_s0_waitrequest    (o_s0_waitrequest),
        .i_s1_addr           (i_s1_addr),
        .i_s1_byte_en        (i_s1_byte_en),
        .i_s1_writedata      (i_s1_writedata),
        .i_s1_read           (i_s1_read),
        .i_s1_write          (i_s1_write),
        .o_s1_readdata       (o_s1_readdata),
        .o_s1_readdata_valid (o_s1_readdata_valid),
        .o_s1_waitrequest    (o_s1_waitrequest),
        .o_m_addr            (o_m_addr),
        .o_m_byte_en         (o_m_byte_en),
        .o_m_writedata       (o_m_writedata),
        .o_m_read            (o_m_read),
        .o_m_write           (o_m_write),
        .i_m_readdata        (i_m_readdata),
        .i_m_readdata_valid  (i_m_readdata_valid),
        .i_m_waitrequest     (i_m_waitrequest),
        .o_busy              (o_busy),
        .o_err               (o_err),
        .cnt_stall0          (cnt_stall0),
        .cnt_stall1          (cnt_stall1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [25:0]  addr;
        logic [127:0] data;
        logic [3:0]   be;
    } cmd_t;

    typedef struct {
        int           port;
        logic [127:0] data;
    } rd_t;

    cmd_t cmdQ[$];
    rd_t  rdQ[$];

    int compared   = 0;
    int mismatched = 0;

    // Memory model configuration, written only by the main process.
    int memWait   = 0;
    int memLat    = 2;
    int injectReq = 0;

    // Observation counters, written only by the monitor.
    int validCnt0   = 0;
    int validCnt1   = 0;
    int writeCycles = 0;
    int s1WaitLow   = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expectCmd(input bit wr, input logic [25:0] addr, input logic [127:0] data, input logic [3:0] be);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.data = data; c.be = be;
        cmdQ.push_back(c);
    endtask

    task automatic expectRd(input int port, input logic [127:0] data);
        rd_t r;
        r.port = port; r.data = data;
        rdQ.push_back(r);
    endtask

    function automatic logic [127:0] memDefault(input logic [25:0] a);
        if (a == 26'h100) return {16{8'hA5}};
        return {4{6'b0, a}};
    endfunction

    // Behavioural memory: configurable command stall and read latency.
    // Evaluated 2 time units after the falling edge.
    initial begin : mem_model
        logic [127:0] mem [logic [25:0]];
        bit           pending;
        int           latCnt;
        int           waitCnt;
        int           injectSeen;
        logic [127:0] pendData;
        pending = 0; latCnt = 0; waitCnt = 0; injectSeen = 0; pendData = '0;
        i_m_readdata = '0; i_m_readdata_valid = 1'b0; i_m_waitrequest = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                pending = 0; waitCnt = 0;
                i_m_readdata_valid = 1'b0; i_m_waitrequest = 1'b1;
            end else begin
                i_m_readdata_valid = 1'b0;
                if (injectReq != injectSeen) begin
                    injectSeen = injectReq;
                    i_m_readdata_valid = 1'b1;
                    i_m_readdata = {4{32'hDEADBEEF}};
                end
                if (pending) begin
                    if (latCnt == 0) begin
                        i_m_readdata_valid = 1'b1;
                        i_m_readdata = pendData;
                        pending = 0;
                    end else begin
                        latCnt--;
                    end
                end
                if (o_m_read || o_m_write) begin
                    if (waitCnt < memWait) begin
                        i_m_waitrequest = 1'b1;
                        waitCnt++;
                    end else begin
                        i_m_waitrequest = 1'b0;
                        waitCnt = 0;
                        if (o_m_read) begin
                            pending = 1;
                            latCnt = memLat;
                            pendData = mem.exists(o_m_addr) ? mem[o_m_addr] : memDefault(o_m_addr);
                        end else begin
                            mem[o_m_addr] = o_m_writedata;
                        end
                    end
                end else begin
                    i_m_waitrequest = 1'b1;
                    waitCnt = 0;
                end
            end
        end
    end

    // Monitor: compares accepted memory commands and forwarded read data
    // against the scoreboard queues.
    initial begin : monitor
        cmd_t c;
        rd_t  r;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                if (o_m_write) writeCycles++;
                if (!o_s1_waitrequest) s1WaitLow++;
                if ((o_m_read || o_m_write) && !i_m_waitrequest) begin
                    if (cmdQ.size() == 0) begin
                        compared++; mismatched++;
                        $display("[TB] FAIL unexpected_cmd: got addr %0h, expected no command", o_m_addr);
                    end else begin
                        c = cmdQ.pop_front();
                        checkOutput("cmd_write", o_m_write, c.wr);
                        checkOutput("cmd_read", o_m_read, !c.wr);
                        checkOutput("cmd_addr", o_m_addr, c.addr);
                        checkOutput("cmd_be", o_m_byte_en, c.be);
                        if (c.wr) checkOutput("cmd_wdata", o_m_writedata, c.data);
                    end
                end
                if (o_s0_readdata_valid && o_s1_readdata_valid) begin
                    compared++; mismatched++;
                    $display("[TB] FAIL dual_valid: got both valids, expected at most one");
                end
                if (o_s0_readdata_valid || o_s1_readdata_valid) begin
                    if (o_s0_readdata_valid) validCnt0++;
                    if (o_s1_readdata_valid) validCnt1++;
                    if (rdQ.size() == 0) begin
                        compared++; mismatched++;
                        $display("[TB] FAIL unexpected_valid: got valid, expected none");
                    end else begin
                        r = rdQ.pop_front();
                        checkOutput("rd_port", o_s1_readdata_valid ? 1 : 0, r.port);
                        checkOutput("rd_data", o_s1_readdata_valid ? o_s1_readdata : o_s0_readdata, r.data);
                    end
                end
            end
        end
    end

    // One master request: raise the strobe, hold it until the arbiter
    // lowers waitrequest, drop it on the following falling edge.
    task automatic applyStimulus(input int port, input bit wr, input logic [25:0] addr, input logic [127:0] data);
        int budget;
        bit done;
        budget = 200;
        done = 0;
        if (port == 0) begin
            i_s0_addr = addr; i_s0_writedata = data; i_s0_byte_en = 4'h3;
            i_s0_read = !wr; i_s0_write = wr;
        end else begin
            i_s1_addr = addr; i_s1_writedata = data; i_s1_byte_en = 4'hC;
            i_s1_read = !wr; i_s1_write = wr;
        end
        while (!done && budget > 0) begin
            @(negedge clk);
            #4;
            if (((port == 0) ? o_s0_waitrequest : o_s1_waitrequest) == 1'b0) done = 1;
            budget--;
        end
        @(negedge clk);
        if (port == 0) begin
            i_s0_read = 1'b0; i_s0_write = 1'b0;
        end else begin
            i_s1_read = 1'b0; i_s1_write = 1'b0;
        end
        if (!done) begin
            compared++; mismatched++;
            $display("[TB] FAIL accept_timeout port %0d: got no accept, expected accept within 200 cycles", port);
        end
    endtask

    task automatic waitIdle();
        int budget;
        budget = 200;
        do begin
            @(negedge clk);
            #6;
            budget--;
        end while (o_busy && budget > 0);
        if (o_busy) begin
            compared++; mismatched++;
            $display("[TB] FAIL idle_timeout: got busy, expected idle within 200 cycles");
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int b0, b1, bw;
        rst_n = 1'b0;
        i_s0_addr = '0; i_s0_byte_en = '0; i_s0_writedata = '0; i_s0_read = 0; i_s0_write = 0;
        i_s1_addr = '0; i_s1_byte_en = '0; i_s1_writedata = '0; i_s1_read = 0; i_s1_write = 0;
        repeat (3) @(negedge clk);
        #6;

        // Reset values.
        checkOutput("rst_m_read", o_m_read, 0);
        checkOutput("rst_m_write", o_m_write, 0);
        checkOutput("rst_m_addr", o_m_addr, 0);
        checkOutput("rst_s0_wait", o_s0_waitrequest, 1);
        checkOutput("rst_s1_wait", o_s1_waitrequest, 1);
        checkOutput("rst_s0_valid", o_s0_readdata_valid, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_err", o_err, 0);
        checkOutput("rst_cnt0", cnt_stall0, 0);
        checkOutput("rst_cnt1", cnt_stall1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // s0 read alone, memory stall 2, data 5 cycles after accept.
        $display("[TB] single s0 read");
        memWait = 2; memLat = 4;
        b0 = validCnt0; b1 = validCnt1; bw = s1WaitLow;
        expectCmd(0, 26'h100, '0, 4'h3);
        expectRd(0, {16{8'hA5}});
        applyStimulus(0, 0, 26'h100, '0);
        waitIdle();
        repeat (2) @(negedge clk);
        #6;
        checkOutput("t1_s0_valid_pulses", validCnt0 - b0, 1);
        checkOutput("t1_s1_valid_pulses", validCnt1 - b1, 0);
        checkOutput("t1_s1_wait_low_cycles", s1WaitLow - bw, 0);

        // Simultaneous reads after reset: strict alternation starting at s0.
        $display("[TB] dual reads after reset");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        memWait = 1; memLat = 2;
        for (int k = 0; k < 4; k++) begin
            expectCmd(0, 26'h200, '0, 4'h3);
            expectRd(0, {4{32'h00000200}});
            expectCmd(0, 26'h300, '0, 4'hC);
            expectRd(1, {4{32'h00000300}});
        end
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    applyStimulus(0, 0, 26'h200, '0);
                    @(negedge clk);
                end
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    applyStimulus(1, 0, 26'h300, '0);
                    @(negedge clk);
                end
            end
        join
        waitIdle();
        checkOutput("t2_stall1_gt_stall0", (cnt_stall1 > cnt_stall0), 1);
        checkOutput("t2_queue_drained", rdQ.size(), 0);

        // s1 write: one memory write cycle, straight back to idle.
        $display("[TB] s1 write");
        memWait = 0; memLat = 2;
        bw = writeCycles;
        expectCmd(1, 26'h12345, {128{1'b1}}, 4'hC);
        applyStimulus(1, 1, 26'h12345, {128{1'b1}});
        #6;
        checkOutput("t3_idle_after_write", o_busy, 0);
        checkOutput("t3_write_cycles", writeCycles - bw, 1);
        @(negedge clk);
        expectCmd(0, 26'h12345, '0, 4'h3);
        expectRd(0, {128{1'b1}});
        applyStimulus(0, 0, 26'h12345, '0);
        waitIdle();

        // Spurious read data while idle.
        $display("[TB] spurious read data");
        b0 = validCnt0; b1 = validCnt1;
        @(negedge clk);
        injectReq = injectReq + 1;
        repeat (2) @(negedge clk);
        #6;
        checkOutput("t4_err_set", o_err, 1);
        checkOutput("t4_no_valid", (validCnt0 - b0) + (validCnt1 - b1), 0);
        @(negedge clk);
        expectCmd(0, 26'h300, '0, 4'hC);
        expectRd(1, {4{32'h00000300}});
        applyStimulus(1, 0, 26'h300, '0);
        waitIdle();
        checkOutput("t4_err_sticky", o_err, 1);

        // Reset while waiting for read data.
        $display("[TB] reset in RDWAIT");
        memWait = 0; memLat = 8;
        b0 = validCnt0;
        expectCmd(0, 26'h100, '0, 4'h3);
        applyStimulus(0, 0, 26'h100, '0);
        #6;
        checkOutput("t5_in_rdwait", o_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_busy", o_busy, 0);
        checkOutput("t5_async_s0_wait", o_s0_waitrequest, 1);
        checkOutput("t5_async_s1_wait", o_s1_waitrequest, 1);
        checkOutput("t5_async_err", o_err, 0);
        checkOutput("t5_async_cnt0", cnt_stall0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        memLat = 2;
        @(negedge clk);
        expectCmd(0, 26'h300, '0, 4'hC);
        expectRd(1, {4{32'h00000300}});
        applyStimulus(1, 0, 26'h300, '0);
        waitIdle();
        repeat (12) @(negedge clk);
        #6;
        checkOutput("t5_no_stale_s0_valid", validCnt0 - b0, 0);
        checkOutput("t5_cmd_queue_drained", cmdQ.size(), 0);
        checkOutput("t5_rd_queue_drained", rdQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
